// File: rtl/vga_timing_gen_mc_if.sv
// Mode-request channel of the video timing generator.
//   cfg_res/fp/pulse/bp_x  requested horizontal timing (C_bits_x each)
//   cfg_res/fp/pulse/bp_y  requested vertical timing   (C_bits_y each)
//   cfg_valid              one-cycle request strobe
//   cfg_ack                one-cycle pulse when the requested mode goes live
//   cfg_err                one-cycle pulse when a request is rejected
// master drives the request, slave (the generator) answers with ack/err.
interface vga_timing_gen_mc_if #(
  parameter int C_bits_x = 11,
  parameter int C_bits_y = 11
);
  logic [C_bits_x-1:0] cfg_res_x;
  logic [C_bits_x-1:0] cfg_fp_x;
  logic [C_bits_x-1:0] cfg_pulse_x;
  logic [C_bits_x-1:0] cfg_bp_x;
  logic [C_bits_y-1:0] cfg_res_y;
  logic [C_bits_y-1:0] cfg_fp_y;
  logic [C_bits_y-1:0] cfg_pulse_y;
  logic [C_bits_y-1:0] cfg_bp_y;
  logic                cfg_valid;
  logic                cfg_ack;
  logic                cfg_err;

  modport master (
    output cfg_res_x, cfg_fp_x, cfg_pulse_x, cfg_bp_x,
    output cfg_res_y, cfg_fp_y, cfg_pulse_y, cfg_bp_y,
    output cfg_valid,
    input  cfg_ack, cfg_err
  );

  modport slave (
    input  cfg_res_x, cfg_fp_x, cfg_pulse_x, cfg_bp_x,
    input  cfg_res_y, cfg_fp_y, cfg_pulse_y, cfg_bp_y,
    input  cfg_valid,
    output cfg_ack, cfg_err
  );
endinterface

// File: rtl/vga_timing_gen_mc.sv
// Runtime-reconfigurable video timing generator with colour-bar test picture.
// Ports:
//   clk_pixel, reset_n      pixel clock, async active-low reset
//   cfg                     mode-request channel (slave side)
//   test_picture            1 = colour bars on rgb
//   vga_hsync/vsync/blank   sync and blank, polarity set by C_*sync_pol
//   x, y                    coordinates of the pixel currently on the outputs
//   frame_start/line_start  strobes for x=0,y=0 and x=0
//   frame_cnt               16-bit frame counter
//   vga_r/g/b               test picture, C_depth bits per channel
// All outputs are registered from the (hc,vc) counters, one cycle behind.
// A new mode is held pending and swapped in only on the last pixel of a frame.
module vga_timing_gen_mc #(
  parameter int C_bits_x    = 11,
  parameter int C_bits_y    = 11,
  parameter int C_depth     = 8,
  parameter int C_hsync_pol = 0,
  parameter int C_vsync_pol = 0,
  parameter int C_res_x     = 1024,
  parameter int C_fp_x      = 24,
  parameter int C_pulse_x   = 136,
  parameter int C_bp_x      = 160,
  parameter int C_res_y     = 768,
  parameter int C_fp_y      = 3,
  parameter int C_pulse_y   = 6,
  parameter int C_bp_y      = 29
) (
  input  logic                clk_pixel,
  input  logic                reset_n,
  vga_timing_gen_mc_if.slave  cfg,
  input  logic                test_picture,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic                vga_blank,
  output logic [C_bits_x-1:0] x,
  output logic [C_bits_y-1:0] y,
  output logic                frame_start,
  output logic                line_start,
  output logic [15:0]         frame_cnt,
  output logic [C_depth-1:0]  vga_r,
  output logic [C_depth-1:0]  vga_g,
  output logic [C_depth-1:0]  vga_b
);

  localparam int WX = C_bits_x + 2;
  localparam int WY = C_bits_y + 2;
  localparam logic [WX-1:0] L_max_x = WX'(1) << C_bits_x;
  localparam logic [WY-1:0] L_max_y = WY'(1) << C_bits_y;
  localparam logic L_hs_on = 1'(C_hsync_pol);
  localparam logic L_vs_on = 1'(C_vsync_pol);
  localparam int L_bw_rst = ((C_res_x >> 3) == 0) ? 1 : (C_res_x >> 3);

  // active mode
  logic [C_bits_x-1:0] r_res_x, r_fp_x, r_pulse_x, r_bp_x;
  logic [C_bits_y-1:0] r_res_y, r_fp_y, r_pulse_y, r_bp_y;
  logic [C_bits_x-1:0] r_bw;
  // pending request
  logic [C_bits_x-1:0] r_pend_res_x, r_pend_fp_x, r_pend_pulse_x, r_pend_bp_x;
  logic [C_bits_y-1:0] r_pend_res_y, r_pend_fp_y, r_pend_pulse_y, r_pend_bp_y;
  logic                r_pend_vld;
  logic                r_applied;
  logic                r_cfg_ack;
  logic                r_cfg_err;

  logic [C_bits_x-1:0] r_hc;
  logic [C_bits_y-1:0] r_vc;
  logic [C_bits_x-1:0] r_sub;
  logic [2:0]          r_bar;

  logic [WX-1:0] w_tot_x, w_hs_start, w_hs_end, w_hc_ext, w_req_tot_x;
  logic [WY-1:0] w_tot_y, w_vs_start, w_vs_end, w_vc_ext, w_req_tot_y;
  logic          w_hc_last, w_vc_last, w_apply, w_req_ok;
  logic          w_blank, w_hs_act, w_vs_act, w_border, w_origin;
  logic [C_bits_x-1:0] w_pend_bw8, w_pend_bw;
  logic [2:0]    w_rgb_on;

  function automatic logic [WX-1:0] sum_x(input logic [C_bits_x-1:0] a, b, c, d);
    return WX'(a) + WX'(b) + WX'(c) + WX'(d);
  endfunction

  function automatic logic [WY-1:0] sum_y(input logic [C_bits_y-1:0] a, b, c, d);
    return WY'(a) + WY'(b) + WY'(c) + WY'(d);
  endfunction

  assign w_tot_x    = sum_x(r_res_x, r_fp_x, r_pulse_x, r_bp_x);
  assign w_tot_y    = sum_y(r_res_y, r_fp_y, r_pulse_y, r_bp_y);
  assign w_hs_start = WX'(r_res_x) + WX'(r_fp_x);
  assign w_hs_end   = w_hs_start + WX'(r_pulse_x);
  assign w_vs_start = WY'(r_res_y) + WY'(r_fp_y);
  assign w_vs_end   = w_vs_start + WY'(r_pulse_y);
  assign w_hc_ext   = WX'(r_hc);
  assign w_vc_ext   = WY'(r_vc);
  assign w_hc_last  = (w_hc_ext == w_tot_x - WX'(1));
  assign w_vc_last  = (w_vc_ext == w_tot_y - WY'(1));
  assign w_apply    = w_hc_last && w_vc_last;
  assign w_origin   = (r_hc == '0) && (r_vc == '0);

  assign w_req_tot_x = sum_x(cfg.cfg_res_x, cfg.cfg_fp_x, cfg.cfg_pulse_x, cfg.cfg_bp_x);
  assign w_req_tot_y = sum_y(cfg.cfg_res_y, cfg.cfg_fp_y, cfg.cfg_pulse_y, cfg.cfg_bp_y);
  assign w_req_ok    = (cfg.cfg_res_x != '0) && (cfg.cfg_res_y != '0) &&
                       (w_req_tot_x <= L_max_x) && (w_req_tot_y <= L_max_y);

  assign w_pend_bw8 = r_pend_res_x >> 3;
  assign w_pend_bw  = (w_pend_bw8 == '0) ? C_bits_x'(1) : w_pend_bw8;

  // Mode register and request handling. The capture is written after the
  // apply so a request arriving on the apply cycle stays pending.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_res_x        <= C_bits_x'(C_res_x);
      r_fp_x         <= C_bits_x'(C_fp_x);
      r_pulse_x      <= C_bits_x'(C_pulse_x);
      r_bp_x         <= C_bits_x'(C_bp_x);
      r_res_y        <= C_bits_y'(C_res_y);
      r_fp_y         <= C_bits_y'(C_fp_y);
      r_pulse_y      <= C_bits_y'(C_pulse_y);
      r_bp_y         <= C_bits_y'(C_bp_y);
      r_bw           <= C_bits_x'(L_bw_rst);
      r_pend_res_x   <= '0;
      r_pend_fp_x    <= '0;
      r_pend_pulse_x <= '0;
      r_pend_bp_x    <= '0;
      r_pend_res_y   <= '0;
      r_pend_fp_y    <= '0;
      r_pend_pulse_y <= '0;
      r_pend_bp_y    <= '0;
      r_pend_vld     <= 1'b0;
      r_applied      <= 1'b0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_applied <= 1'b0;
      r_cfg_err <= 1'b0;
      if (w_apply && r_pend_vld) begin
        r_res_x    <= r_pend_res_x;
        r_fp_x     <= r_pend_fp_x;
        r_pulse_x  <= r_pend_pulse_x;
        r_bp_x     <= r_pend_bp_x;
        r_res_y    <= r_pend_res_y;
        r_fp_y     <= r_pend_fp_y;
        r_pulse_y  <= r_pend_pulse_y;
        r_bp_y     <= r_pend_bp_y;
        r_bw       <= w_pend_bw;
        r_pend_vld <= 1'b0;
        r_applied  <= 1'b1;
      end
      if (cfg.cfg_valid) begin
        if (w_req_ok) begin
          r_pend_res_x   <= cfg.cfg_res_x;
          r_pend_fp_x    <= cfg.cfg_fp_x;
          r_pend_pulse_x <= cfg.cfg_pulse_x;
          r_pend_bp_x    <= cfg.cfg_bp_x;
          r_pend_res_y   <= cfg.cfg_res_y;
          r_pend_fp_y    <= cfg.cfg_fp_y;
          r_pend_pulse_y <= cfg.cfg_pulse_y;
          r_pend_bp_y    <= cfg.cfg_bp_y;
          r_pend_vld     <= 1'b1;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_hc_last) begin
      r_hc <= '0;
      r_vc <= w_vc_last ? '0 : r_vc + 1'b1;
    end else begin
      r_hc <= r_hc + 1'b1;
    end
  end

  // Bar index tracks hc: both restart together with hc=0.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      r_sub <= '0;
      r_bar <= 3'd0;
    end else if (w_hc_last) begin
      r_sub <= '0;
      r_bar <= 3'd0;
    end else if (r_sub == r_bw - 1'b1) begin
      r_sub <= '0;
      if (r_bar != 3'd7) r_bar <= r_bar + 3'd1;
    end else begin
      r_sub <= r_sub + 1'b1;
    end
  end

  assign w_blank  = (w_hc_ext >= WX'(r_res_x)) || (w_vc_ext >= WY'(r_res_y));
  // start == end when pulse is 0, so the sync never asserts
  assign w_hs_act = (w_hc_ext >= w_hs_start) && (w_hc_ext < w_hs_end);
  assign w_vs_act = (w_vc_ext >= w_vs_start) && (w_vc_ext < w_vs_end);
  assign w_border = (r_hc == '0) || (w_hc_ext == WX'(r_res_x) - WX'(1)) ||
                    (r_vc == '0) || (w_vc_ext == WY'(r_res_y) - WY'(1));

  // Bar order white..black maps to r=~bar[1], g=~bar[2], b=~bar[0].
  always_comb begin
    w_rgb_on = 3'b000;
    if (!w_blank && test_picture) begin
      if (w_border) w_rgb_on = 3'b111;
      else          w_rgb_on = {~r_bar[1], ~r_bar[2], ~r_bar[0]};
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      vga_hsync   <= ~L_hs_on;
      vga_vsync   <= ~L_vs_on;
      vga_blank   <= 1'b1;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      frame_cnt   <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      r_cfg_ack   <= 1'b0;
    end else begin
      vga_hsync   <= w_hs_act ? L_hs_on : ~L_hs_on;
      vga_vsync   <= w_vs_act ? L_vs_on : ~L_vs_on;
      vga_blank   <= w_blank;
      x           <= r_hc;
      y           <= r_vc;
      frame_start <= w_origin;
      line_start  <= (r_hc == '0);
      if (w_origin) frame_cnt <= frame_cnt + 16'd1;
      vga_r       <= {C_depth{w_rgb_on[2]}};
      vga_g       <= {C_depth{w_rgb_on[1]}};
      vga_b       <= {C_depth{w_rgb_on[0]}};
      // r_applied is high while hc=vc=0 of the new mode, so the ack lines
      // up with that frame's frame_start
      r_cfg_ack   <= r_applied;
    end
  end

  assign cfg.cfg_ack = r_cfg_ack;
  assign cfg.cfg_err = r_cfg_err;

endmodule

// File: tb/tb_vga_timing_gen_mc.sv
// Directed bench for vga_timing_gen_mc. The reset mode is shrunk to
// 40/4/6/6 x 20/2/3/5 (56 x 30 = 1680 clk per frame) so that several frame
// boundaries, and therefore mode changes, fit in a short run.
// Output cycle k (k-th falling edge after reset release, from 0) shows pixel k.
module tb_vga_timing_gen_mc;
  logic        clk_pixel = 1'b0;
  logic        reset_n;
  logic        test_picture;
  logic        vga_hsync, vga_vsync, vga_blank;
  logic [10:0] x;
  logic [10:0] y;
  logic        frame_start, line_start;
  logic [15:0] frame_cnt;
  logic [7:0]  vga_r, vga_g, vga_b;

  int cyc;
  int n_vec  = 0;
  int n_miss = 0;

  vga_timing_gen_mc_if #(.C_bits_x(11), .C_bits_y(11)) cfg_if ();

  vga_timing_gen_mc #(
    .C_bits_x(11), .C_bits_y(11), .C_depth(8),
    .C_hsync_pol(0), .C_vsync_pol(0),
    .C_res_x(40), .C_fp_x(4), .C_pulse_x(6), .C_bp_x(6),
    .C_res_y(20), .C_fp_y(2), .C_pulse_y(3), .C_bp_y(5)
  ) dut (
    .clk_pixel   (clk_pixel),
    .reset_n     (reset_n),
    .cfg         (cfg_if),
    .test_picture(test_picture),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_blank   (vga_blank),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .line_start  (line_start),
    .frame_cnt   (frame_cnt),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(negedge clk_pixel);
      cyc++;
    end
  endtask

  task automatic send_cfg(input int rx, fx, px, bx, ry, fy, py, by);
    cfg_if.cfg_res_x   = 11'(rx);
    cfg_if.cfg_fp_x    = 11'(fx);
    cfg_if.cfg_pulse_x = 11'(px);
    cfg_if.cfg_bp_x    = 11'(bx);
    cfg_if.cfg_res_y   = 11'(ry);
    cfg_if.cfg_fp_y    = 11'(fy);
    cfg_if.cfg_pulse_y = 11'(py);
    cfg_if.cfg_bp_y    = 11'(by);
    cfg_if.cfg_valid   = 1'b1;
    goto(cyc + 1);
    cfg_if.cfg_valid   = 1'b0;
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, vga_r, vga_g, vga_b};
  endfunction

  logic [23:0] bars [8];

  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'hFFFFFF;

    reset_n = 1'b0;
    test_picture = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_res_x = '0; cfg_if.cfg_fp_x = '0; cfg_if.cfg_pulse_x = '0; cfg_if.cfg_bp_x = '0;
    cfg_if.cfg_res_y = '0; cfg_if.cfg_fp_y = '0; cfg_if.cfg_pulse_y = '0; cfg_if.cfg_bp_y = '0;
    cyc = -10;
    goto(-7);

    check_val("rst_hsync", 32'(vga_hsync), 32'd1);
    check_val("rst_vsync", 32'(vga_vsync), 32'd1);
    check_val("rst_blank", 32'(vga_blank), 32'd1);
    check_val("rst_fs", 32'(frame_start), 32'd0);
    check_val("rst_ls", 32'(line_start), 32'd0);
    check_val("rst_fcnt", 32'(frame_cnt), 32'd0);
    check_val("rst_ack", 32'(cfg_if.cfg_ack), 32'd0);
    check_val("rst_err", 32'(cfg_if.cfg_err), 32'd0);
    check_val("rst_rgb", rgb(), 32'd0);

    reset_n = 1'b1;
    cyc = -1;

    // reset mode 56 x 30
    goto(0);
    check_val("d_fs0", 32'(frame_start), 32'd1);
    check_val("d_ls0", 32'(line_start), 32'd1);
    check_val("d_fcnt1", 32'(frame_cnt), 32'd1);
    check_val("d_x0", 32'(x), 32'd0);
    check_val("d_blank0", 32'(vga_blank), 32'd0);
    check_val("d_ack0", 32'(cfg_if.cfg_ack), 32'd0);
    goto(43);
    check_val("d_x43", 32'(x), 32'd43);
    check_val("d_hs43", 32'(vga_hsync), 32'd1);
    check_val("d_blank43", 32'(vga_blank), 32'd1);
    goto(44); check_val("d_hs44", 32'(vga_hsync), 32'd0);
    goto(49); check_val("d_hs49", 32'(vga_hsync), 32'd0);
    goto(50); check_val("d_hs50", 32'(vga_hsync), 32'd1);
    goto(56);
    check_val("d_ls56", 32'(line_start), 32'd1);
    check_val("d_fs56", 32'(frame_start), 32'd0);
    check_val("d_y56", 32'(y), 32'd1);
    goto(1231); check_val("d_vs_l21", 32'(vga_vsync), 32'd1);
    goto(1232);
    check_val("d_vs_l22", 32'(vga_vsync), 32'd0);
    check_val("d_y22", 32'(y), 32'd22);
    goto(1400); check_val("d_vs_l25", 32'(vga_vsync), 32'd1);
    goto(1679); check_val("d_fs1679", 32'(frame_start), 32'd0);
    goto(1680);
    check_val("d_fs1680", 32'(frame_start), 32'd1);
    check_val("d_fcnt2", 32'(frame_cnt), 32'd2);

    // small mode 8/1/2/1 x 4/1/1/1 -> 12 x 7
    send_cfg(8, 1, 2, 1, 4, 1, 1, 1);
    check_val("s_err", 32'(cfg_if.cfg_err), 32'd0);
    goto(3359);
    check_val("s_fs_pre", 32'(frame_start), 32'd0);
    check_val("s_ack_pre", 32'(cfg_if.cfg_ack), 32'd0);
    goto(3360);
    check_val("s_fs", 32'(frame_start), 32'd1);
    check_val("s_ack", 32'(cfg_if.cfg_ack), 32'd1);
    check_val("s_fcnt3", 32'(frame_cnt), 32'd3);
    goto(3361); check_val("s_ack_once", 32'(cfg_if.cfg_ack), 32'd0);
    goto(3367); check_val("s_blank_x7", 32'(vga_blank), 32'd0);
    goto(3368); check_val("s_blank_x8", 32'(vga_blank), 32'd1);
    goto(3369); check_val("s_hs_x9", 32'(vga_hsync), 32'd0);
    goto(3370); check_val("s_hs_x10", 32'(vga_hsync), 32'd0);
    goto(3371); check_val("s_hs_x11", 32'(vga_hsync), 32'd1);
    goto(3419); check_val("s_vs_l4", 32'(vga_vsync), 32'd1);
    goto(3420);
    check_val("s_vs_l5", 32'(vga_vsync), 32'd0);
    check_val("s_y5", 32'(y), 32'd5);
    goto(3432); check_val("s_vs_l6", 32'(vga_vsync), 32'd1);
    goto(3444);
    check_val("s_fs84", 32'(frame_start), 32'd1);
    check_val("s_fcnt4", 32'(frame_cnt), 32'd4);

    // test picture
    check_val("tp_off", rgb(), 32'd0);
    test_picture = 1'b1;
    goto(3447); check_val("tp_border_y0", rgb(), 32'hFFFFFF);
    for (int i = 0; i < 8; i++) begin
      goto(3456 + i);
      check_val($sformatf("tp_bar%0d", i), rgb(), 32'(bars[i]));
    end
    goto(3464); check_val("tp_blank", rgb(), 32'd0);
    goto(3471); check_val("tp_y2x3", rgb(), 32'h00FF00);
    goto(3472);
    test_picture = 1'b0;
    goto(3473); check_val("tp_disabled", rgb(), 32'd0);

    // two requests in one frame: last one (small) wins, single ack
    goto(3530); send_cfg(16, 1, 1, 2, 4, 1, 1, 1);
    goto(3540); send_cfg(8, 1, 2, 1, 4, 1, 1, 1);
    goto(3612);
    check_val("dbl_fs", 32'(frame_start), 32'd1);
    check_val("dbl_ack", 32'(cfg_if.cfg_ack), 32'd1);
    goto(3624); check_val("dbl_y1", 32'(y), 32'd1);
    goto(3695); check_val("dbl_fs_pre", 32'(frame_start), 32'd0);
    goto(3696);
    check_val("dbl_fs2", 32'(frame_start), 32'd1);
    check_val("dbl_no_ack2", 32'(cfg_if.cfg_ack), 32'd0);

    // A pending, B requested on the apply cycle: A now, B one frame later
    goto(3700); send_cfg(16, 1, 1, 2, 4, 1, 1, 1);
    goto(3778); send_cfg(8, 1, 2, 1, 5, 1, 1, 1);
    goto(3780);
    check_val("ap_fsA", 32'(frame_start), 32'd1);
    check_val("ap_ackA", 32'(cfg_if.cfg_ack), 32'd1);
    goto(3799); check_val("ap_xA19", 32'(x), 32'd19);
    goto(3919); check_val("ap_fsA_pre", 32'(frame_start), 32'd0);
    goto(3920);
    check_val("ap_fsB", 32'(frame_start), 32'd1);
    check_val("ap_ackB", 32'(cfg_if.cfg_ack), 32'd1);
    goto(4004); check_val("ap_yB7", 32'(y), 32'd7);
    goto(4015); check_val("ap_fsB_pre", 32'(frame_start), 32'd0);
    goto(4016);
    check_val("ap_fsB2", 32'(frame_start), 32'd1);
    check_val("ap_noackB2", 32'(cfg_if.cfg_ack), 32'd0);

    // rejected requests
    goto(4020); send_cfg(0, 1, 2, 1, 4, 1, 1, 1);
    check_val("rej_resx0", 32'(cfg_if.cfg_err), 32'd1);
    goto(4022); check_val("rej_resx0_end", 32'(cfg_if.cfg_err), 32'd0);
    goto(4030); send_cfg(2000, 20, 20, 9, 4, 1, 1, 1);
    check_val("rej_tot2049", 32'(cfg_if.cfg_err), 32'd1);
    goto(4032); check_val("rej_tot_end", 32'(cfg_if.cfg_err), 32'd0);
    goto(4111); check_val("rej_fs_pre", 32'(frame_start), 32'd0);
    goto(4112);
    check_val("rej_fs", 32'(frame_start), 32'd1);
    check_val("rej_noack", 32'(cfg_if.cfg_ack), 32'd0);

    // reset mid-frame with a request pending
    goto(4120); send_cfg(8, 1, 2, 1, 4, 1, 1, 1);
    goto(4130);
    reset_n = 1'b0;
    #1;
    check_val("mr_x", 32'(x), 32'd0);
    check_val("mr_y", 32'(y), 32'd0);
    check_val("mr_blank", 32'(vga_blank), 32'd1);
    check_val("mr_hsync", 32'(vga_hsync), 32'd1);
    check_val("mr_fcnt", 32'(frame_cnt), 32'd0);
    goto(4133);
    reset_n = 1'b1;
    cyc = -1;
    goto(0);
    check_val("mr_fs0", 32'(frame_start), 32'd1);
    check_val("mr_fcnt1", 32'(frame_cnt), 32'd1);
    goto(44); check_val("mr_hs44", 32'(vga_hsync), 32'd0);
    goto(56); check_val("mr_y56", 32'(y), 32'd1);
    goto(1679); check_val("mr_fs_pre", 32'(frame_start), 32'd0);
    goto(1680);
    check_val("mr_fs1680", 32'(frame_start), 32'd1);
    check_val("mr_noack", 32'(cfg_if.cfg_ack), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen_mc.md
Name: vga_timing_gen_mc

Overview:
- Parametrised, runtime-reconfigurable video timing generator with a built-in test picture, running in the pixel clock domain.
- Generates hsync/vsync/blank, pixel coordinates, frame/line strobes and optional colour-bar RGB for the vga2dvid encoder.
- Video mode can be changed at run time; the new mode takes effect only on a frame boundary, so it never tears.
- Successor to the fixed-mode generator: adds mode handshake, sync polarity, frame counter and a configurable depth.

Parameters:
- C_bits_x, 11, width of horizontal counter and config fields
- C_bits_y, 11, width of vertical counter and config fields
- C_depth, 8, bits per colour channel of rgb outputs
- C_hsync_pol, 0, active level of hsync (0 = active-low)
- C_vsync_pol, 0, active level of vsync
- C_res_x / C_fp_x / C_pulse_x / C_bp_x, 1024/24/136/160, reset horizontal mode
- C_res_y / C_fp_y / C_pulse_y / C_bp_y, 768/3/6/29, reset vertical mode

Ports:
- clk_pixel  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_res_x, cfg_fp_x, cfg_pulse_x, cfg_bp_x  in  C_bits_x each  requested horizontal timing
- cfg_res_y, cfg_fp_y, cfg_pulse_y, cfg_bp_y  in  C_bits_y each  requested vertical timing
- cfg_valid  in  1  one-cycle request: capture the cfg_* fields
- cfg_ack  out  1  one-cycle pulse when the new mode becomes active
- cfg_err  out  1  one-cycle pulse when a request is rejected
- test_picture  in  1  1 = drive colour bars on the rgb outputs
- vga_hsync, vga_vsync, vga_blank  out  1 each  sync and blank outputs
- x, y  out  C_bits_x / C_bits_y  coordinates of the current output pixel
- frame_start, line_start  out  1 each  strobes
- frame_cnt  out  16  frame counter
- vga_r, vga_g, vga_b  out  C_depth each  test picture

Behaviour:
- Reset (async assert, sync release): active mode loads the C_* defaults; pending request cleared.
- Output values in reset: counters 0; x=y=0; vga_hsync=~C_hsync_pol; vga_vsync=~C_vsync_pol; vga_blank=1; strobes, cfg_ack, cfg_err, frame_cnt and rgb all 0.
- Totals: tot_x = res_x+fp_x+pulse_x+bp_x, computed at C_bits_x+2 bits; tot_y likewise.
- Counter hc runs 0..tot_x-1 and wraps. vc increments when hc wraps, runs 0..tot_y-1 and wraps.
- All outputs are registered from (hc,vc), giving 1 cycle latency. x/y are registered copies, so every output in a cycle describes the same pixel.
- vga_blank = (hc >= res_x) or (vc >= res_y).
- hsync is active when res_x+fp_x <= hc < res_x+fp_x+pulse_x. vsync uses the same rule on vc and is line-granular, with no half-line offset.
- pulse = 0: that sync output never asserts.
- line_start=1 when output x=0. frame_start=1 when output x=0 and y=0. The first frame_start comes on the first edge after reset release.
- frame_cnt increments by 1, wrapping 0xFFFF->0, in the same cycle that frame_start is asserted.
- Config capture: on cfg_valid, all cfg_* fields are latched into a pending register and the pending flag is set.
- A new cfg_valid while pending overwrites the pending register; only the last request is applied and only one cfg_ack is produced.
- Apply point: the cycle with hc=tot_x-1 and vc=tot_y-1 of the active mode.
  - If pending, the active mode is replaced by the pending register and the pending flag is cleared.
  - On the next cycle hc=vc=0 under the new mode, and cfg_ack pulses in the same cycle that frame_start is asserted for that frame.
- cfg_valid in the apply cycle itself: the new request is held pending for the next frame boundary. The old pending value is applied now.
- Rejection: res_x=0, res_y=0, tot_x>2^C_bits_x or tot_y>2^C_bits_y → cfg_err pulses 1 cycle after cfg_valid. Pending is not modified and the active mode is unaffected.
- Test picture, when test_picture=1:
  - Eight vertical bars, in this order: white, yellow, cyan, green, magenta, red, blue, black. Each colour component is either all-ones or 0.
  - Bar width bw = max(1, res_x>>3), computed at mode apply.
  - A sub-counter counts to bw-1 and then advances the bar index. Both counters reset at hc=0; the bar index saturates at 7.
  - A 1-pixel border (output x=0, x=res_x-1, y=0 or y=res_y-1) is white.
- test_picture=0 → rgb=0. During blank → rgb=0 regardless of test_picture.
- test_picture is sampled each cycle; there is no frame alignment.
- Reset asserted mid-frame: everything returns to the reset values immediately, and any pending request is lost.

Test Plan:
- Defaults after reset: measure periods → hsync period 1344 clk, low for 136 clk starting 1048 clk after line_start; vsync low for 6 lines starting at line 771; frame period 1344*806 clk; frame_cnt increments once per frame.
- Small mode: cfg 8/1/2/1 x, 4/1/1/1 y → cfg_ack coincides with the next frame_start, and thereafter:
  - blank is low for x=0..7 only;
  - hsync is active at x=9..10;
  - vsync is active on line 5;
  - the frame is 12*7=84 clk.
- Two cfg_valid pulses in one frame (modes A, then small mode above) → a single cfg_ack, and the small mode is active; cfg_valid in the apply cycle → applied one frame later.
- Rejected config: res_x=0, and separately tot_x=2049 with C_bits_x=11 → cfg_err pulses, no cfg_ack, timing unchanged.
- Test picture in small mode (res_x=8, bw=1): line y=1 rgb = white, yellow, cyan, green, magenta, red, blue, white (border), all 0xFF/0x00 levels; blank pixels give rgb=0; test_picture=0 gives rgb=0.
- Reset asserted mid-frame with a request pending → outputs at reset values at once; after release the C_* default mode runs and no cfg_ack is produced.
